// File: rtl/sat_accum_stage.sv
// Saturating frame accumulator: sums COUNT samples, decodes the first-beat one-hot select,
// and presents one stable result per frame on a valid/ready output.
module sat_accum_stage #(
    parameter int DATA_W = 8,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [1:0]        out_code,
    output logic              out_ovf,
    output logic              out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_C = 8'(COUNT);

    state_t state, state_nxt;

    logic [DATA_W-1:0] acc;
    logic [7:0]        cnt;
    logic              ovf;
    logic [1:0]        code_r;
    logic              err_r;

    logic              fire;
    logic              last_beat;
    logic [DATA_W:0]   tmp;
    logic [DATA_W-1:0] acc_nxt;
    logic              ovf_nxt;
    logic [7:0]        cnt_nxt;
    logic [1:0]        dec_code;
    logic              dec_err;

    assign fire = in_valid && in_ready;

    always_comb begin
        dec_code = 2'b00;
        dec_err  = 1'b0;
        case (in_sel)
            4'b0001: dec_code = 2'b11;
            4'b0010: dec_code = 2'b10;
            4'b0100: dec_code = 2'b01;
            4'b1000: dec_code = 2'b00;
            default: begin
                dec_code = 2'b00;
                dec_err  = 1'b1;
            end
        endcase
    end

    // The first beat of a frame loads rather than adds, so ovf restarts clean per frame.
    always_comb begin
        tmp     = {1'b0, acc} + {1'b0, in_data};
        acc_nxt = acc;
        ovf_nxt = ovf;
        cnt_nxt = cnt;
        if (state == IDLE) begin
            acc_nxt = in_data;
            ovf_nxt = 1'b0;
            cnt_nxt = 8'd1;
        end else begin
            if (tmp[DATA_W]) begin
                acc_nxt = {DATA_W{1'b1}};
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = tmp[DATA_W-1:0];
            end
            cnt_nxt = cnt + 8'd1;
        end
    end

    // COUNT >= 2, so the IDLE beat can never be the frame's last one.
    assign last_beat = fire && (state == ACCUM) && (cnt_nxt == COUNT_C);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (fire) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            code_r   <= 2'b00;
            err_r    <= 1'b0;
            out_sum  <= '0;
            out_code <= 2'b00;
            out_ovf  <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            if (fire) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
                cnt <= cnt_nxt;
                if (state == IDLE) begin
                    code_r <= dec_code;
                    err_r  <= dec_err;
                end
            end
            // Result registers only change on entry to HOLD, so they are stable until the handshake.
            if (last_beat) begin
                out_sum  <= acc_nxt;
                out_ovf  <= ovf_nxt;
                out_code <= code_r;
                out_err  <= err_r;
            end
            if (state == HOLD && out_ready) cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sat_accum_stage.sv
// Directed and randomized frames for sat_accum_stage against a plain-arithmetic reference.
module tb_sat_accum_stage;

    localparam int DW  = 8;
    localparam int CNT = 4;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [3:0]    in_sel;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic [1:0]    out_code;
    logic          out_ovf;
    logic          out_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int sum;
        int code;
        int ovf;
        int err;
    } res_t;

    always #5 clk = ~clk;

    sat_accum_stage #(.DATA_W(DW), .COUNT(CNT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_code(out_code), .out_ovf(out_ovf), .out_err(out_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Saturating sum of nonnegative samples equals min(total, max); it overflowed iff total > max.
    function automatic res_t model(input int d[CNT], input logic [3:0] sel);
        res_t r;
        int total = 0;
        int ones = 0;
        r.code = 0;
        for (int i = 0; i < CNT; i++) total += d[i];
        r.sum = (total > MAXV) ? MAXV : total;
        r.ovf = (total > MAXV) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                ones++;
                r.code = 3 - k;
            end
        end
        if (ones != 1) begin
            r.code = 0;
            r.err = 1;
        end else begin
            r.err = 0;
        end
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vld"}, out_valid, 0);
        chk({tag, "_sum"}, out_sum, 0);
        chk({tag, "_code"}, out_code, 0);
        chk({tag, "_ovf"}, out_ovf, 0);
        chk({tag, "_err"}, out_err, 0);
        chk({tag, "_rdy"}, in_ready, 1);
    endtask

    task automatic drive_beat(input int v, input logic [3:0] sel, input int gap, input string tag);
        int t = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = v[DW-1:0];
        in_sel   = sel;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        chk({tag, "_beat_rdy"}, in_ready, 1);
        chk({tag, "_beat_novld"}, out_valid, 0);
        step();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_sel   = 4'($urandom);
    endtask

    task automatic run_frame(input int d[CNT], input logic [3:0] sel0, input logic [3:0] sel_later,
                             input int g[CNT], input int stall, input string tag);
        res_t r;
        logic [DW+3:0] snap;
        r = model(d, sel0);
        for (int i = 0; i < CNT; i++)
            drive_beat(d[i], (i == 0) ? sel0 : sel_later, g[i], tag);
        chk({tag, "_lat_vld"}, out_valid, 1);
        chk({tag, "_hold_rdy"}, in_ready, 0);
        snap = {out_sum, out_code, out_ovf, out_err};
        repeat (stall) begin
            step();
            chk({tag, "_stall_vld"}, out_valid, 1);
            chk({tag, "_stall_rdy"}, in_ready, 0);
            chk({tag, "_stall_stable"}, {out_sum, out_code, out_ovf, out_err}, snap);
        end
        chk({tag, "_sum"}, out_sum, r.sum);
        chk({tag, "_code"}, out_code, r.code);
        chk({tag, "_ovf"}, out_ovf, r.ovf);
        chk({tag, "_err"}, out_err, r.err);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done_vld"}, out_valid, 0);
        chk({tag, "_done_rdy"}, in_ready, 1);
        chk({tag, "_keep_sum"}, out_sum, r.sum);
    endtask

    initial begin
        int d[CNT];
        int g[CNT];
        int z[CNT];
        logic [3:0] s0;

        z = '{0, 0, 0, 0};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_sel = '0;
        out_ready = 1'b0;
        step();
        step();
        chk_reset_outputs("por");
        rst = 1'b0;
        step();

        run_frame('{10, 20, 30, 40}, 4'b0010, 4'b0010, z, 0, "basic");
        run_frame('{200, 100, 0, 5}, 4'b0001, 4'b0001, z, 0, "sat");
        run_frame('{255, 0, 0, 0}, 4'b0100, 4'b0100, z, 0, "exact_max");
        run_frame('{1, 2, 3, 4}, 4'b0110, 4'b0001, z, 0, "illegal");
        run_frame('{9, 9, 9, 9}, 4'b0000, 4'b1000, z, 0, "zero_sel");
        run_frame('{5, 6, 7, 8}, 4'b1000, 4'b0100, z, 5, "bp");
        run_frame('{11, 22, 33, 44}, 4'b0001, 4'b0010, '{0, 2, 1, 0}, 0, "bubbles");

        // Reset mid-frame, with a beat offered during reset that must be ignored.
        drive_beat(7, 4'b0001, 0, "mid");
        drive_beat(9, 4'b0001, 0, "mid");
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd50;
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        chk_reset_outputs("mid_rst");
        run_frame('{1, 1, 1, 1}, 4'b0010, 4'b0010, z, 0, "after_mid");

        // Reset while a result is pending in HOLD.
        for (int i = 0; i < CNT; i++) drive_beat(30, 4'b0100, 0, "hrst");
        chk("hrst_vld", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("hold_rst");
        step();
        chk("hold_rst_novld", out_valid, 0);

        for (int f = 0; f < 150; f++) begin
            for (int i = 0; i < CNT; i++) begin
                d[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 80);
                g[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            end
            s0 = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            run_frame(d, s0, 4'($urandom), g, $urandom_range(0, 3), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sat_accum_stage.md
# sat_accum_stage

Downstream arithmetic stage that consumes the 8-bit operand stream produced by the register-update block. It accumulates a fixed-length frame of samples into a saturating sum and decodes the frame's one-hot select into a 2-bit code. It presents one result per frame on a valid/ready output. Arithmetic overflow and illegal selects are flagged explicitly rather than wrapping silently.

## Interface
- DATA_W, 8, width of input samples and of the output sum
- COUNT, 4, samples per frame; legal range is 2..255
- clk  input  1  rising-edge clock; the block uses one clock
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  upstream sample is valid
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  DATA_W  unsigned sample
- in_sel  input  4  one-hot select; sampled only on the first beat of each frame
- out_valid  output  1  frame result is held on the outputs
- out_ready  input  1  downstream accepts the result
- out_sum  output  DATA_W  saturated unsigned sum of the frame
- out_code  output  2  decoded select code
- out_ovf  output  1  sum saturated at least once during the frame
- out_err  output  1  first-beat in_sel was not one-hot

## Operation
- A beat is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: in_ready=1. An accepted beat loads acc=in_data, latches code and err from in_sel, sets cnt=1, then goes to ACCUM.
  - ACCUM: in_ready=1. Each accepted beat adds in_data to acc and increments cnt. The beat that makes cnt==COUNT moves the FSM to HOLD.
  - HOLD: in_ready=0, out_valid=1, outputs are stable. If out_ready=1, the FSM goes to IDLE on the next cycle.
- Addition rule:
  - tmp = {1'b0,acc} + {1'b0,in_data}, computed at DATA_W+1 bits.
  - If tmp[DATA_W]=1, then acc <= {DATA_W{1'b1}} and ovf <= 1.
  - Otherwise acc <= tmp[DATA_W-1:0].
  - Once acc is all-ones it stays all-ones. A beat of value 0 does not clear ovf.
- Select decode (full case, default required):
  - 0001->11, 0010->10, 0100->01, 1000->00.
  - Any other value, including 0000 and multi-hot values, gives code=00 and err=1.
- Select is captured once per frame. in_sel on later beats is ignored.
- cnt is 8 bits. It is cleared on leaving HOLD and never wraps within a frame.
- No beats are accepted in HOLD. Upstream stalls through back-pressure.
- out_sum, out_code, out_ovf and out_err are driven from the HOLD registers. In IDLE and ACCUM they hold the last frame's value; downstream uses only out_valid.

## Timing
- Reset, synchronous: on any rising clk with rst=1:
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_sum=0, out_code=00, out_ovf=0, out_err=0.
  - in_ready=1 in the cycle after reset.
- Reset mid-frame or in HOLD discards the partial or pending result. No out_valid pulse follows.
- rst takes priority over every simultaneous handshake.
- Latency: out_valid rises in the cycle after the COUNT-th accepted beat.
- Minimum frame period is COUNT+1 cycles: COUNT beats plus at least one HOLD cycle.
- HOLD with out_ready=1 in its first cycle: out_valid is high for exactly one cycle. in_ready returns to 1 in the following cycle. There is no same-cycle pass-through.
- out_valid, once high, stays high and outputs do not change until the out_ready handshake (AXI-style stability).
- Gaps in in_valid during ACCUM stall the frame without time-out. acc and cnt are held.

## Test plan
- Basic frame, COUNT=4, in_sel=0010: beats 10, 20, 30, 40 -> out_sum=100, out_code=10, out_ovf=0, out_err=0. out_valid rises 1 cycle after beat 4.
- Saturation: beats 200, 100, 0, 5 -> out_sum=255, out_ovf=1. acc stays 255 after the beats of 0 and 5.
- Illegal select: in_sel=0110 on beat 1, then in_sel=0001 on beats 2-4 -> out_code=00, out_err=1. The later selects are ignored.
- Back-pressure: hold out_ready=0 for 5 cycles in HOLD.
  - in_ready=0 and outputs stay stable throughout.
  - Raising out_ready gives IDLE next cycle, and a new frame starts after that.
- Reset mid-frame: apply rst after 2 of 4 beats, then send a full frame 1, 1, 1, 1 -> only one out_valid, with out_sum=4. Reset values are checked on all outputs.
- Bubbles: in_valid toggling 1, 0, 0, 1, 0, 1, 1 -> frame completes on the 4th accepted beat with the correct sum. cnt and acc do not change on idle cycles.
